// File: rtl/hash_mem_server.sv
// Word memory and job sequencer for the SHA-256 hash engine. The host loads message
// words, the engine is started and served, and result words are streamed back to the host.
module hash_mem_server #(
  parameter int DEPTH     = 64,
  parameter int MSG_BASE  = 0,
  parameter int MSG_WORDS = 20,
  parameter int OUT_BASE  = 32,
  parameter int OUT_WORDS = 1,
  parameter int TIMEOUT   = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic        res_last,
  input  logic        res_ready,
  output logic        start,
  input  logic        done,
  output logic [15:0] message_addr,
  output logic [15:0] output_addr,
  input  logic [15:0] mem_addr,
  input  logic        mem_we,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic        timeout,
  output logic        addr_err,
  output logic [2:0]  o_dbg_state
);

  // Both streams use valid/ready: a beat transfers on a cycle where valid && ready;
  // the sender holds data stable while valid is high and ready is low.

  localparam int              AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [16:0]     DEPTH_LIM = 17'(DEPTH);
  localparam logic [AW-1:0]   MSG_LAST  = AW'(MSG_WORDS - 1);
  localparam logic [AW-1:0]   OUT_LAST  = AW'(OUT_WORDS - 1);
  localparam logic [AW-1:0]   MSG_OFS   = AW'(MSG_BASE);
  localparam logic [AW-1:0]   OUT_OFS   = AW'(OUT_BASE);
  localparam logic [31:0]     WDOG_LIM  = 32'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_LOAD    = 3'd0,
    S_START   = 3'd1,
    S_WAIT_LO = 3'd2,
    S_WAIT_HI = 3'd3,
    S_DRAIN   = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_ld_cnt;
  logic [AW-1:0] r_rd_cnt;
  logic [31:0]   r_wdog;
  logic          r_timeout;
  logic          r_addr_err;

  logic          w_ld_fire;
  logic          w_res_fire;
  logic          w_in_wait;
  logic          w_addr_ok;
  logic          w_wdog_exp;
  logic          w_rd_last;
  logic [AW-1:0] w_ld_addr;
  logic [AW-1:0] w_rd_addr;

  assign w_ld_fire  = ld_valid && ld_ready;
  assign w_res_fire = res_valid && res_ready;
  assign w_in_wait  = (r_state == S_WAIT_LO) || (r_state == S_WAIT_HI);
  assign w_addr_ok  = {1'b0, mem_addr} < DEPTH_LIM;
  assign w_wdog_exp = w_in_wait && (r_wdog == WDOG_LIM);
  assign w_rd_last  = (r_rd_cnt == OUT_LAST);
  assign w_ld_addr  = MSG_OFS + r_ld_cnt;
  assign w_rd_addr  = OUT_OFS + r_rd_cnt;

  assign message_addr  = 16'(MSG_BASE);
  assign output_addr   = 16'(OUT_BASE);
  assign timeout       = r_timeout;
  assign addr_err      = r_addr_err;
  assign o_dbg_state   = r_state;
  // Out-of-range engine reads return zero rather than aliasing into the array.
  assign mem_read_data = w_addr_ok ? r_mem[mem_addr[AW-1:0]] : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_LOAD;
      r_ld_cnt   <= '0;
      r_rd_cnt   <= '0;
      r_wdog     <= '0;
      r_timeout  <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_ld_fire) r_ld_cnt <= r_ld_cnt + 1'b1;
      if (r_state == S_START) begin
        r_timeout  <= 1'b0;
        r_addr_err <= 1'b0;
        r_wdog     <= '0;
      end
      if (w_in_wait) begin
        r_wdog <= r_wdog + 32'd1;
        if (w_wdog_exp) r_timeout <= 1'b1;
        if (mem_we && !w_addr_ok) r_addr_err <= 1'b1;
      end
      if (w_res_fire) begin
        if (w_rd_last) begin
          r_rd_cnt <= '0;
          r_ld_cnt <= '0;
        end else begin
          r_rd_cnt <= r_rd_cnt + 1'b1;
        end
      end
    end
  end

  // Memory contents survive reset; host and engine writes never share a state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_ld_fire) r_mem[w_ld_addr] <= ld_data;
      else if (w_in_wait && mem_we && w_addr_ok) r_mem[mem_addr[AW-1:0]] <= mem_write_data;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LOAD:    if (w_ld_fire && ((r_ld_cnt == MSG_LAST) || ld_last)) w_next = S_START;
      S_START:   w_next = S_WAIT_LO;
      S_WAIT_LO: if (w_wdog_exp) w_next = S_DRAIN;
                 else if (!done) w_next = S_WAIT_HI;
      S_WAIT_HI: if (w_wdog_exp || done) w_next = S_DRAIN;
      S_DRAIN:   if (w_res_fire && w_rd_last) w_next = S_LOAD;
      default:   w_next = S_LOAD;
    endcase
  end

  always_comb begin
    ld_ready  = 1'b0;
    start     = 1'b0;
    res_valid = 1'b0;
    res_data  = 32'h0;
    res_last  = 1'b0;
    case (r_state)
      S_LOAD:  ld_ready = 1'b1;
      S_START: start = 1'b1;
      S_DRAIN: begin
        res_valid = 1'b1;
        res_data  = r_mem[w_rd_addr];
        res_last  = w_rd_last;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/hash_mem_server.md
Name: hash_mem_server

Overview:
Memory-side responder and sequencer for the SHA-256/bitcoin hash engine. It owns the word memory the engine reads the message from and writes the digest into. A host loads message words over a valid/ready stream, and the block pulses start to the engine. It serves the engine's memory port, captures engine writes, waits for completion, then streams result words back to the host.

Parameters:
DEPTH, 64, memory depth in 32-bit words (power of 2, ≤ 65536)
MSG_BASE, 0, word address of first message word; driven on message_addr
MSG_WORDS, 20, number of message words loaded per job
OUT_BASE, 32, word address of first result word; driven on output_addr
OUT_WORDS, 1, number of result words drained per job
TIMEOUT, 4096, watchdog limit in cycles for the wait phase

Ports:
clk  in  1  single clock; all logic on posedge
reset  in  1  synchronous, active-high reset
ld_valid  in  1  host message word valid
ld_data  in  32  host message word
ld_last  in  1  host marks final word (early termination allowed)
ld_ready  out  1  block accepts message word
res_valid  out  1  result word valid
res_data  out  32  result word
res_last  out  1  final result word
res_ready  in  1  host accepts result word
start  out  1  one-cycle job start to hash engine
done  in  1  engine done/idle level (high when idle)
message_addr  out  16  constant MSG_BASE
output_addr  out  16  constant OUT_BASE
mem_addr  in  16  engine word address (registered by engine)
mem_we  in  1  engine write enable
mem_write_data  in  32  engine write data
mem_read_data  out  32  read data to engine
timeout  out  1  sticky: watchdog expired on last job
addr_err  out  1  sticky: engine accessed address ≥ DEPTH

Behaviour:
- Reset: state LOAD; ld_cnt=0, rd_cnt=0, wdog=0. Outputs: start=0, res_valid=0, res_data=0, res_last=0, timeout=0, addr_err=0. Memory contents are not reset.
- Read path: mem_read_data = mem[mem_addr] combinationally (zero-cycle). The engine registers mem_addr at edge N and samples data at edge N+1. If mem_addr ≥ DEPTH, mem_read_data=0 and there is no aliasing.
- States: LOAD, START, WAIT_LO, WAIT_HI, DRAIN.
- LOAD:
  - ld_ready=1.
  - On ld_valid&&ld_ready: mem[MSG_BASE+ld_cnt]<=ld_data; ld_cnt++.
  - When that beat is number MSG_WORDS, or carries ld_last: go START. Unwritten message words keep their old contents.
  - Engine writes are ignored in LOAD.
- START:
  - start=1 for exactly this cycle.
  - timeout<=0, addr_err<=0, wdog<=0.
  - Next state: WAIT_LO.
- WAIT_LO: wait for done==0 (engine acknowledged), then go WAIT_HI.
- WAIT_HI: wait for done==1, then go DRAIN.
- Engine writes: in WAIT_LO and WAIT_HI, mem_we=1 with mem_addr<DEPTH writes mem[mem_addr]<=mem_write_data. mem_we=1 with mem_addr≥DEPTH sets addr_err<=1 and writes nothing. A write in the same cycle done rises is captured.
- Watchdog: wdog increments each cycle in WAIT_LO and WAIT_HI. At wdog==TIMEOUT-1: timeout<=1, go DRAIN.
- DRAIN:
  - res_valid=1, res_data=mem[OUT_BASE+rd_cnt], res_last=(rd_cnt==OUT_WORDS-1).
  - On res_valid&&res_ready: rd_cnt++.
  - After the last handshake: rd_cnt=0, ld_cnt=0, go LOAD.
  - res_data/res_last hold stable while res_ready=0.
- Addresses: MSG_BASE+ld_cnt and OUT_BASE+rd_cnt use 16-bit arithmetic. Parameters guarantee both ranges lie in [0,DEPTH); no wrap.
- Reset mid-operation: any state returns to LOAD next edge. A start pulse in progress is cut. The engine is reset separately by the system.
- timeout and addr_err hold until the next START.

Test Plan:
- Load words 0x00..0x13 (20 beats, ld_valid held 1) -> ld_ready drops after beat 20; start=1 exactly one cycle later; mem[MSG_BASE+k]=k.
- Combinational read: after load, drive mem_addr=MSG_BASE+3 -> mem_read_data=0x00000003 same cycle.
- Engine model: done falls 2 cycles after start, writes 0xDEADBEEF to addr 32 with mem_we=1, done rises next cycle -> res_valid=1, res_data=0xDEADBEEF, res_last=1.
- Backpressure: hold res_ready=0 for 5 cycles in DRAIN -> res_data stable; exactly one handshake when raised; then ld_ready=1 next cycle.
- done stuck high after start, TIMEOUT=16 -> timeout=1 after 16 wait cycles; DRAIN entered; timeout cleared at next START.
- Engine write to mem_addr=0x0100 (DEPTH=64) -> addr_err=1; mem[0] unchanged; read of 0x0100 returns 0.
- Assert reset during WAIT_HI -> next cycle all outputs at reset values and ld_ready=1; an ld_last beat at ld_cnt=5 -> START immediately.
